wb_mem_slave: RTL

Wishbone B4 pipelined responder backed by an on-chip word memory. It is the target end of the JTAG-driven Wishbone bus: the VJTAG bridge issues single reads and writes, and this block accepts them, commits writes, and returns acknowledgements and read data after a fixed latency. It also provides programmable stall injection, so the initiator's back-pressure path is exercised on hardware and in simulation.

---
 rtl/wb_mem_slave.sv | 122 ++++++++++++
 1 files changed

// File: rtl/wb_mem_slave.sv
// Wishbone B4 pipelined memory responder: fixed-latency acks, programmable stall injection.
// Define WB_MEM_ERR_EN to answer out-of-range addresses with wb_err_o instead of wb_ack_o.
module wb_mem_slave #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int MEM_DEPTH    = 256,
    parameter int LATENCY      = 1,
    parameter int STALL_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [ADDR_WIDTH-1:0] wb_adr_i,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_stall_o,
    output logic                  wb_err_o
);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    typedef enum logic {READY, HOLD} state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  vld_p [LATENCY];
    logic                  err_p [LATENCY];
    logic [DATA_WIDTH-1:0] dat_p [LATENCY];

    state_t           state;
    logic [2:0]       cnt;
    logic             stall;
    logic             accept;
    logic             in_range;
    logic             err_bit;
    logic [IDX_W-1:0] idx;

    assign accept   = wb_cyc_i && wb_stb_i && !stall && !rst;
    assign in_range = {1'b0, wb_adr_i} < DEPTH_L;
    assign idx      = wb_adr_i[IDX_W-1:0];

`ifdef WB_MEM_ERR_EN
    assign err_bit = !in_range;
`else
    assign err_bit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (accept && wb_we_i && in_range) begin
            mem[idx] <= wb_dat_i;
        end
    end

    // stage 0 captures the response at acceptance; later stages only delay it
    always_ff @(posedge clk) begin
        if (rst || !wb_cyc_i) begin
            for (int i = 0; i < LATENCY; i++) begin
                vld_p[i] <= 1'b0;
            end
        end else begin
            vld_p[0] <= accept;
            for (int i = 1; i < LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        err_p[0] <= err_bit;
        dat_p[0] <= (!wb_we_i && in_range) ? mem[idx] : '0;
        for (int i = 1; i < LATENCY; i++) begin
            err_p[i] <= err_p[i-1];
            dat_p[i] <= dat_p[i-1];
        end
    end

    // output stage
    assign wb_ack_o = vld_p[LATENCY-1] && !err_p[LATENCY-1];
    assign wb_dat_o = wb_ack_o ? dat_p[LATENCY-1] : '0;

`ifdef WB_MEM_ERR_EN
    assign wb_err_o = vld_p[LATENCY-1] && err_p[LATENCY-1];
`else
    assign wb_err_o = 1'b0;
`endif

    // stall injection keeps counting through a bus abort
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= READY;
            cnt   <= '0;
            stall <= 1'b0;
        end else begin
            case (state)
                READY: begin
                    if (accept && (STALL_CYCLES > 0)) begin
                        state <= HOLD;
                        cnt   <= 3'(STALL_CYCLES);
                        stall <= 1'b1;
                    end
                end
                HOLD: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        state <= READY;
                        stall <= 1'b0;
                    end
                end
                default: begin
                    state <= READY;
                    stall <= 1'b0;
                end
            endcase
        end
    end

    assign wb_stall_o = stall;

endmodule
